// File: rtl/buyruk_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// instruction field layout and operation-type encodings.
package buyruk_pkg;

    localparam int ADRES_W  = 13;
    localparam int SAYI_W   = 32;
    localparam int ISLEM_W  = 2;
    localparam int BUYRUK_W = ISLEM_W + 2 * SAYI_W + ADRES_W;

    // Field offsets (LSB positions) within an instruction word
    localparam int ADRES_LSB = 0;
    localparam int SAYI2_LSB = ADRES_LSB + ADRES_W;
    localparam int SAYI1_LSB = SAYI2_LSB + SAYI_W;
    localparam int ISLEM_LSB = SAYI1_LSB + SAYI_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic [ISLEM_W-1:0] {
        ISLEM_TOPLA = 2'd0,
        ISLEM_CIKAR = 2'd1,
        ISLEM_CARP  = 2'd2,
        ISLEM_BOL   = 2'd3
    } islem_e;

    function automatic islem_e islem_turu_al(input logic [BUYRUK_W-1:0] buyruk);
        return islem_e'(buyruk[ISLEM_LSB +: ISLEM_W]);
    endfunction

endpackage

// File: rtl/buyruk_fifo.sv
// Small circular FIFO with an asynchronous head view; push is ignored when
// full and pop is ignored when empty.
module buyruk_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 79
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/buyruk_siralayici.sv
// Instruction sequencer: round-robin intake from two requesters into a FIFO,
// one-at-a-time issue with completion wait. BUYRUK_SIRALAYICI_TIMEOUT_EN adds the watchdog.
module buyruk_siralayici
    import buyruk_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int BUYRUK_W = buyruk_pkg::BUYRUK_W
`ifdef BUYRUK_SIRALAYICI_TIMEOUT_EN
    , parameter int TIMEOUT = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [BUYRUK_W-1:0] req0_buyruk,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [BUYRUK_W-1:0] req1_buyruk,
    output logic                req1_ready,
    output logic                issue_valid,
    output logic [BUYRUK_W-1:0] issue_buyruk,
    input  logic                issue_ready,
    input  logic                bitti,
    output logic                busy,
    output logic                zaman_asimi,
    output logic [15:0]         sayac
);

    state_e                    state_q, state_d;
    logic                      last_q, last_d;   // 1: requester 1 was served last
    logic [15:0]               sayac_q, sayac_d;
    logic                      grant0, grant1;
    logic                      push, pop;
    logic [BUYRUK_W-1:0]       push_data;
    logic [BUYRUK_W-1:0]       fifo_head;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      fifo_full, fifo_empty;

`ifdef BUYRUK_SIRALAYICI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] timer_q, timer_d;
`endif

    buyruk_fifo #(
        .DEPTH (DEPTH),
        .W     (BUYRUK_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Full is a registered flag, so a same-cycle pop never frees a slot
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_q);
        grant1     = req1_valid & (~req0_valid | ~last_q);
        req0_ready = grant0 & ~fifo_full;
        req1_ready = grant1 & ~fifo_full;
        push       = req0_ready | req1_ready;
        push_data  = req0_ready ? req0_buyruk : req1_buyruk;
        last_d     = last_q;
        if (req0_ready) begin
            last_d = 1'b0;
        end else if (req1_ready) begin
            last_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sayac_d     = sayac_q;
        pop         = 1'b0;
        issue_valid = 1'b0;
        zaman_asimi = 1'b0;
`ifdef BUYRUK_SIRALAYICI_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) begin
                    pop     = 1'b1;
                    state_d = WAIT;
`ifdef BUYRUK_SIRALAYICI_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            WAIT: begin
                // Completion takes priority over a coincident watchdog expiry
                if (bitti) begin
                    sayac_d = sayac_q + 16'd1;
                    state_d = IDLE;
                end
`ifdef BUYRUK_SIRALAYICI_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    zaman_asimi = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sayac_q <= '0;
`ifdef BUYRUK_SIRALAYICI_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sayac_q <= sayac_d;
`ifdef BUYRUK_SIRALAYICI_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign issue_buyruk = issue_valid ? fifo_head : '0;
    assign busy         = (state_q != IDLE) | ~fifo_empty;
    assign sayac        = sayac_q;

endmodule
